// File: rtl/roll_histogram_pkg.sv
// Shared types and helpers for the roll histogram block.
// Optional min/max face tracking is enabled with ROLL_HIST_MINMAX_EN.
package roll_hist_pkg;

    localparam int DEFAULT_NUM_FACES = 20;

    typedef enum logic [1:0] {
        D4  = 2'b00,
        D6  = 2'b01,
        D8  = 2'b10,
        D20 = 2'b11
    } die_sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Highest legal face for each die type.
    function automatic logic [4:0] max_face(input die_sel_t die);
        case (die)
            D4:      max_face = 5'd4;
            D6:      max_face = 5'd6;
            D8:      max_face = 5'd8;
            default: max_face = 5'd20;
        endcase
    endfunction

endpackage

// File: rtl/roll_histogram_if.sv
// Sample/control/read bundle between the dice roller side and the histogram.
// min_face/max_face exist only when ROLL_HIST_MINMAX_EN is defined.
interface roll_histogram_if #(
    parameter int CNT_W = 16,
    parameter int VAL_W = 8
);
    logic             face_valid;
    logic [VAL_W-1:0] face_value;
    logic [1:0]       die_select;
    logic             clear_req;
    logic             clear_busy;
    logic [4:0]       rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic [CNT_W-1:0] total_count;
    logic [CNT_W-1:0] err_count;
    logic             range_err;
`ifdef ROLL_HIST_MINMAX_EN
    logic [VAL_W-1:0] min_face;
    logic [VAL_W-1:0] max_face;

    modport master (
        output face_valid, face_value, die_select, clear_req, rd_addr,
        input  clear_busy, rd_data, total_count, err_count, range_err,
               min_face, max_face
    );
    modport slave (
        input  face_valid, face_value, die_select, clear_req, rd_addr,
        output clear_busy, rd_data, total_count, err_count, range_err,
               min_face, max_face
    );
`else
    modport master (
        output face_valid, face_value, die_select, clear_req, rd_addr,
        input  clear_busy, rd_data, total_count, err_count, range_err
    );
    modport slave (
        input  face_valid, face_value, die_select, clear_req, rd_addr,
        output clear_busy, rd_data, total_count, err_count, range_err
    );
`endif
endinterface

// File: rtl/roll_hist_bin.sv
// One saturating occurrence counter; clear has priority over increment.
module roll_hist_bin #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_reg;

    // Count up on inc, hold at all-ones, zero on clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/roll_histogram.sv
// Per-face histogram of dice rolls with range checking, saturating
// statistics, a registered read port and a one-bin-per-cycle sweep clear.
// Define ROLL_HIST_MINMAX_EN to add min_face/max_face tracking.
module roll_histogram
    import roll_hist_pkg::*;
#(
    parameter int NUM_FACES = DEFAULT_NUM_FACES,
    parameter int CNT_W     = 16,
    parameter int VAL_W     = 8
) (
    input logic               clk,
    input logic               rst,
    roll_histogram_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_FACES + 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] clr_idx_reg, clr_idx_next;
    logic [VAL_W-1:0] face_lim;
    logic             in_range;
    logic             sample_ok;
    logic             accept;
    logic             reject;
    logic             clear_start;
    logic [CNT_W-1:0] bin_count [NUM_FACES];
    logic [CNT_W-1:0] rd_mux;
    logic [CNT_W-1:0] rd_data_reg;
    logic [CNT_W-1:0] total_reg;
    logic [CNT_W-1:0] err_reg;
    logic             range_err_reg;

    // Largest legal face for the selected die, never beyond the bin count.
    always_comb begin
        face_lim = VAL_W'(max_face(die_sel_t'(bus.die_select)));
        if (int'(max_face(die_sel_t'(bus.die_select))) > NUM_FACES) begin
            face_lim = VAL_W'(NUM_FACES);
        end
    end

    assign in_range    = (bus.face_value != '0) && (bus.face_value <= face_lim);
    // A clear request in the same cycle wins and the sample is dropped.
    assign sample_ok   = (state_reg == IDLE) && bus.face_valid && !bus.clear_req;
    assign accept      = sample_ok && in_range;
    assign reject      = sample_ok && !in_range;
    assign clear_start = (state_reg == IDLE) && bus.clear_req;

    // State and sweep index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    // Sweep walks 1..NUM_FACES, one bin per cycle, then returns to IDLE.
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            IDLE: begin
                if (bus.clear_req) begin
                    state_next   = CLEAR;
                    clr_idx_next = IDX_W'(1);
                end
            end
            CLEAR: begin
                if (clr_idx_reg == IDX_W'(NUM_FACES)) begin
                    state_next   = IDLE;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx_reg + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_idx_next = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FACES; gi++) begin : g_bin
            logic bin_inc;
            logic bin_clr;
            assign bin_inc = accept && (bus.face_value == VAL_W'(gi + 1));
            assign bin_clr = (state_reg == CLEAR) && (clr_idx_reg == IDX_W'(gi + 1));
            roll_hist_bin #(.CNT_W(CNT_W)) u_bin (
                .clk   (clk),
                .rst   (rst),
                .inc   (bin_inc),
                .clr   (bin_clr),
                .count (bin_count[gi])
            );
        end
    endgenerate

    // Select the addressed bin; address 0 and beyond the last face read 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_FACES; i++) begin
            if (bus.rd_addr == 5'(i + 1)) begin
                rd_mux = bin_count[i];
            end
        end
    end

    // Registered read; a same-cycle update shows up on the following read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_mux;
        end
    end

    // Total/error statistics, zeroed when a sweep starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_reg     <= '0;
            err_reg       <= '0;
            range_err_reg <= 1'b0;
        end else if (clear_start) begin
            total_reg     <= '0;
            err_reg       <= '0;
            range_err_reg <= 1'b0;
        end else if (accept) begin
            if (total_reg != '1) total_reg <= total_reg + 1'b1;
        end else if (reject) begin
            if (err_reg != '1) err_reg <= err_reg + 1'b1;
            range_err_reg <= 1'b1;
        end
    end

`ifdef ROLL_HIST_MINMAX_EN
    logic [VAL_W-1:0] min_reg;
    logic [VAL_W-1:0] max_reg;

    // Extremes of accepted faces since reset or the last clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_reg <= '1;
            max_reg <= '0;
        end else if (clear_start) begin
            min_reg <= '1;
            max_reg <= '0;
        end else if (accept) begin
            if (bus.face_value < min_reg) min_reg <= bus.face_value;
            if (bus.face_value > max_reg) max_reg <= bus.face_value;
        end
    end

    assign bus.min_face = min_reg;
    assign bus.max_face = max_reg;
`endif

    assign bus.clear_busy  = (state_reg == CLEAR);
    assign bus.rd_data     = rd_data_reg;
    assign bus.total_count = total_reg;
    assign bus.err_count   = err_reg;
    assign bus.range_err   = range_err_reg;
endmodule
